timed_coupled_cell: RTL and testbench

Clocked successor to the buffer-chain coupled cell. It implements weight-dependent propagation delay of the phase signal din -> dout with a cycle-accurate timestamped edge queue instead of LUT delay lines. Weights are double-buffered and applied only at safe points, and edges arriving faster than their delay are buffered. Instantiated per (src,dst) pair in the NxN Ising array, with din/sout already in the clk domain.

---
 rtl/timed_cell_pkg.sv | 16 +
 rtl/timed_coupled_cell_if.sv | 10 +
 rtl/edge_delay_queue.sv | 47 ++++
 rtl/timed_coupled_cell.sv | 102 ++++++++++
 tb/tb_timed_coupled_cell.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/timed_cell_pkg.sv
// Shared helpers for the timed coupled cell: weight width and delay arithmetic.
package timed_cell_pkg;

  // Bits needed to hold a weight index 0..n-1.
  function automatic int weight_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Propagation delay in clk cycles for a given number of weight steps.
  function automatic int unsigned delay_cycles(input int unsigned steps,
                                               input int unsigned base,
                                               input int unsigned scale);
    return base + scale * steps;
  endfunction

endpackage

// File: rtl/timed_coupled_cell_if.sv
// Register-write bus of one coupled cell.
interface timed_coupled_cell_if;
  logic        wready;
  logic        wr_addr_match;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output wready, wr_addr_match, wdata, input rdata);
  modport slave  (input wready, wr_addr_match, wdata, output rdata);
endinterface

// File: rtl/edge_delay_queue.sv
// Circular FIFO of timestamped edges with head/tail peek and tail removal.
module edge_delay_queue #(
  parameter int W     = 9,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic         tail_rm,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] head,
  output logic [W-1:0] tail,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, tail_ptr;
  logic [AW:0]   count;

  assign tail_ptr = wr_ptr - 1'b1;
  assign head     = mem[rd_ptr];
  assign tail     = mem[tail_ptr];
  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));

  // Entry storage; written only on push, never needs reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; tail removal rewinds the write pointer.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + AW'(pop);
      wr_ptr <= wr_ptr + AW'(push) - AW'(tail_rm);
      count  <= count + (AW+1)'(push) - (AW+1)'(pop) - (AW+1)'(tail_rm);
    end
  end
endmodule

// File: rtl/timed_coupled_cell.sv
// Weight-dependent din->dout delay using a timestamped edge queue.
module timed_coupled_cell
  import timed_cell_pkg::*;
#(
  parameter int NUM_WEIGHTS = 15,
  parameter int DELAY_SCALE = 2,
  parameter int BASE_DELAY  = 1,
  parameter int EDGE_DEPTH  = 4,
  parameter int CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 axi_rst,
  input  logic                 osc_clear,
  input  logic                 sout,
  input  logic                 din,
  output logic                 dout,
  output logic                 edge_overflow,
  timed_coupled_cell_if.slave  bus
);
  localparam int WEIGHT_W = weight_w(NUM_WEIGHTS);
  localparam logic [WEIGHT_W-1:0] W_MAX = WEIGHT_W'(NUM_WEIGHTS - 1);
  localparam logic [WEIGHT_W-1:0] W_MID = WEIGHT_W'(NUM_WEIGHTS / 2);

  typedef struct packed {
    logic             level;
    logic [CNT_W-1:0] due;
  } entry_t;

  logic [WEIGHT_W-1:0] shadow, active, steps, wr_w;
  logic [CNT_W-1:0]    now, dly, now_d, diff;
  logic                din_q, edge_det, mismatch;
  logic                pop, push, tail_rm, q_empty, q_full;
  logic                wdata_unused;
  entry_t              head, tail, new_e;

  assign edge_det = din ^ din_q;
  assign mismatch = din ^ sout;
  assign steps    = mismatch ? active : (W_MAX - active);
  assign dly      = CNT_W'(delay_cycles(32'(steps), BASE_DELAY, DELAY_SCALE));
  assign now_d    = now + dly;
  assign diff     = now_d - tail.due;

  // New edge is due after its own delay, but never before the current tail.
  always_comb begin
    new_e.level = din;
    new_e.due   = now_d;
    if (!q_empty && (diff[CNT_W-1] || diff == '0)) new_e.due = tail.due + 1'b1;
  end

  assign pop     = !q_empty && (head.due == now) && !osc_clear;
  assign push    = edge_det && !osc_clear && (!q_full || pop);
  assign tail_rm = edge_det && !osc_clear && q_full && !pop;

  assign wr_w         = (bus.wdata[WEIGHT_W-1:0] > W_MAX) ? W_MAX : bus.wdata[WEIGHT_W-1:0];
  assign bus.rdata    = 32'(shadow);
  assign wdata_unused = ^bus.wdata[31:WEIGHT_W];

  edge_delay_queue #(.W($bits(entry_t)), .DEPTH(EDGE_DEPTH)) u_q (
    .clk       (clk),
    .rst       (axi_rst),
    .flush     (osc_clear),
    .push      (push),
    .pop       (pop),
    .tail_rm   (tail_rm),
    .push_data (new_e),
    .head      (head),
    .tail      (tail),
    .empty     (q_empty),
    .full      (q_full)
  );

  // Shadow takes writes; active copies it only when no edge is in flight.
  always_ff @(posedge clk) begin
    if (axi_rst) begin
      shadow <= W_MID;
      active <= W_MID;
    end else begin
      if (bus.wready && bus.wr_addr_match) shadow <= wr_w;
      if (q_empty && !edge_det) active <= shadow;
    end
  end

  // Timestamp, edge history, output phase and sticky overflow.
  always_ff @(posedge clk) begin
    if (axi_rst) begin
      now           <= '0;
      din_q         <= 1'b0;
      dout          <= 1'b0;
      edge_overflow <= 1'b0;
    end else begin
      now   <= now + 1'b1;
      din_q <= din;
      if (osc_clear) begin
        dout          <= din;
        edge_overflow <= 1'b0;
      end else begin
        if (pop)     dout          <= head.level;
        if (tail_rm) edge_overflow <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_timed_coupled_cell.sv
// Directed bench for timed_coupled_cell with an absolute-time reference model.
module tb_timed_coupled_cell;
  localparam int NW    = 15;
  localparam int DS    = 2;
  localparam int BD    = 1;
  localparam int DEPTH = 4;
  localparam int WW    = $clog2(NW);

  logic clk = 1'b0;
  logic axi_rst, osc_clear, sout, din, dout, edge_overflow;

  timed_coupled_cell_if bus();

  timed_coupled_cell #(.NUM_WEIGHTS(NW), .DELAY_SCALE(DS), .BASE_DELAY(BD),
                       .EDGE_DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk           (clk),
    .axi_rst       (axi_rst),
    .osc_clear     (osc_clear),
    .sout          (sout),
    .din           (din),
    .dout          (dout),
    .edge_overflow (edge_overflow),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: edges kept with absolute due times, no modular arithmetic.
  bit m_valid = 0;
  int m_shadow, m_active, m_now;
  bit m_dout, m_ovf, m_dinq;
  bit q_lvl[$];
  int q_due[$];

  task automatic model_tick();
    bit e, mis, pop;
    int dly, due, sz, nxt_active, wv;
    if (axi_rst) begin
      m_valid = 1; m_shadow = NW / 2; m_active = NW / 2; m_now = 0;
      m_dout = 0; m_ovf = 0; m_dinq = 0;
      q_lvl.delete(); q_due.delete();
      return;
    end
    if (!m_valid) return;
    e   = din ^ m_dinq;
    mis = din ^ sout;
    sz  = q_lvl.size();
    pop = (sz > 0) && (q_due[0] == m_now);
    dly = BD + DS * (mis ? m_active : (NW - 1 - m_active));
    due = m_now + dly;
    if (sz > 0 && q_due[sz-1] + 1 > due) due = q_due[sz-1] + 1;
    nxt_active = (sz == 0 && !e) ? m_shadow : m_active;
    if (osc_clear) begin
      q_lvl.delete(); q_due.delete();
      m_dout = din; m_ovf = 0;
    end else begin
      if (pop) begin
        m_dout = q_lvl[0];
        void'(q_lvl.pop_front()); void'(q_due.pop_front());
      end
      if (e) begin
        if (sz == DEPTH && !pop) begin
          void'(q_lvl.pop_back()); void'(q_due.pop_back());
          m_ovf = 1;
        end else begin
          q_lvl.push_back(din); q_due.push_back(due);
        end
      end
    end
    if (bus.wready && bus.wr_addr_match) begin
      wv = int'(bus.wdata) & ((1 << WW) - 1);
      m_shadow = (wv > NW - 1) ? NW - 1 : wv;
    end
    m_active = nxt_active;
    m_dinq   = din;
    m_now++;
  endtask

  always @(posedge clk) model_tick();

  // Every cycle: outputs must track the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_dout", 32'(dout), 32'(m_dout));
      chk("m_rdata", bus.rdata, 32'(m_shadow));
      chk("m_ovf", 32'(edge_overflow), 32'(m_ovf));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input int v);
    bus.wready = 1'b1; bus.wr_addr_match = 1'b1; bus.wdata = 32'(v);
    tick();
    bus.wready = 1'b0; bus.wr_addr_match = 1'b0; bus.wdata = '0;
  endtask

  initial begin
    axi_rst = 1'b1; osc_clear = 1'b0; sout = 1'b0; din = 1'b0;
    bus.wready = 1'b0; bus.wr_addr_match = 1'b0; bus.wdata = '0;
    tick(2);
    axi_rst = 1'b0;
    tick();
    chk("rst_dout", 32'(dout), 0);
    chk("rst_rdata", bus.rdata, 7);
    chk("rst_ovf", 32'(edge_overflow), 0);

    // Default weight 7, match: D = 1 + 2*7 = 15.
    din = 1'b1; sout = 1'b1;
    tick(15); chk("d15_pre", 32'(dout), 0);
    tick(1);  chk("d15_edge", 32'(dout), 1);

    // Weight 0, mismatch: D = 1.
    wr(0); tick();
    chk("w0_rdata", bus.rdata, 0);
    din = 1'b0;
    tick(1); chk("d1_pre", 32'(dout), 1);
    tick(1); chk("d1_edge", 32'(dout), 0);

    // Weight 0, match: D = 1 + 2*14 = 29.
    din = 1'b1;
    tick(29); chk("d29_pre", 32'(dout), 0);
    tick(1);  chk("d29_edge", 32'(dout), 1);

    // Clamp: 15 exceeds the largest weight 14.
    wr(15); tick();
    chk("clamp_rdata", bus.rdata, 14);

    // Weight 14: A mismatch (D=29), B match (D=1) -> B due one after A.
    // A write of 3 lands while both are pending.
    tick();
    din = 1'b0; tick();
    din = 1'b1; tick();
    wr(3);
    chk("w3_rdata", bus.rdata, 3);
    tick(26); chk("a_pre", 32'(dout), 1);
    tick(1);  chk("a_due", 32'(dout), 0);
    tick(1);  chk("b_due", 32'(dout), 1);
    tick(3);

    // After drain, weight 3 mismatch: D = 1 + 2*3 = 7.
    din = 1'b0;
    tick(7); chk("w3_pre", 32'(dout), 1);
    tick(1); chk("w3_edge", 32'(dout), 0);

    // Five back-to-back edges at weight 14 overrun the 4-entry queue.
    wr(14); tick(2);
    sout = 1'b0;
    for (int i = 0; i < 5; i++) begin
      din = ~din; tick();
    end
    chk("ovf_set", 32'(edge_overflow), 1);
    tick(40);
    chk("ovf_level", 32'(dout), 1);
    chk("ovf_sticky", 32'(edge_overflow), 1);

    // Return din to 0 and drain, then stack 3 pending edges ending at din=1.
    sout = 1'b1; din = 1'b0; tick(35);
    chk("pre_osc_dout", 32'(dout), 0);
    sout = 1'b0;
    din = 1'b1; tick();
    din = 1'b0; tick();
    din = 1'b1; tick();
    chk("pend_dout", 32'(dout), 0);
    osc_clear = 1'b1; tick();
    osc_clear = 1'b0;
    chk("osc_dout", 32'(dout), 1);
    chk("osc_ovf", 32'(edge_overflow), 0);
    chk("osc_rdata", bus.rdata, 14);
    tick(40);
    chk("osc_quiet", 32'(dout), 1);

    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
